// File: rtl/wb_stage.sv
// Write-back stage: holds one dual-issue line pair and commits line1 then line2,
// one per cycle. A committing line with an exception flushes the rest of the pair.
module wb_stage #(
  parameter int LINE_W = 77
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line1_pre_to_now_valid_i,
  input  logic                  line2_pre_to_now_valid_i,
  output logic                  now_allowin_o,
  input  logic [2*LINE_W-1:0]   pre_to_ibus,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [31:0]           rf_wdata_o,
  output logic [31:0]           debug_wb_pc_o,
  output logic [3:0]            debug_wb_rf_we_o,
  output logic                  excep_flush_o,
  output logic [31:0]           excep_pc_o,
  output logic [5:0]            excep_ecode_o,
  output logic [75:0]           forward_obus
);

  logic [LINE_W-1:0] r1, r2;
  logic              p1, p2;

  logic [LINE_W-1:0] c_rec;
  logic              has_commit;
  logic              c_excep;
  logic [5:0]        c_ecode;
  logic [31:0]       c_pc;
  logic              c_we;
  logic [4:0]        c_waddr;
  logic [31:0]       c_wdata;
  logic              fwd1_we, fwd2_we;

  // line1 always has priority; line2 commits only once line1 is done
  always_comb begin
    has_commit = p1 | p2;
    c_rec      = '0;
    if (p1)
      c_rec = r1;
    else if (p2)
      c_rec = r2;
    c_excep = c_rec[LINE_W-1];
    c_ecode = c_rec[LINE_W-2 -: 6];
    c_pc    = c_rec[LINE_W-8 -: 32];
    c_we    = c_rec[37];
    c_waddr = c_rec[36:32];
    c_wdata = c_rec[31:0];
  end

  always_comb begin
    excep_flush_o    = has_commit & c_excep;
    excep_pc_o       = excep_flush_o ? c_pc : 32'h0;
    excep_ecode_o    = excep_flush_o ? c_ecode : 6'h0;
    now_allowin_o    = !(p1 && p2) && !excep_flush_o;
    rf_we_o          = has_commit && c_we && !c_excep && (c_waddr != 5'd0);
    rf_waddr_o       = c_waddr;
    rf_wdata_o       = c_wdata;
    debug_wb_pc_o    = c_pc;
    debug_wb_rf_we_o = {4{rf_we_o}};
  end

  always_comb begin
    fwd1_we      = p1 && r1[37] && !r1[LINE_W-1] && (r1[36:32] != 5'd0);
    fwd2_we      = p2 && r2[37] && !r2[LINE_W-1] && (r2[36:32] != 5'd0);
    forward_obus = {fwd2_we, r2[36:32], r2[31:0], fwd1_we, r1[36:32], r1[31:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1 <= '0;
      r2 <= '0;
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else if (now_allowin_o) begin
      r1 <= pre_to_ibus[LINE_W-1:0];
      r2 <= pre_to_ibus[2*LINE_W-1:LINE_W];
      p1 <= line1_pre_to_now_valid_i;
      p2 <= line2_pre_to_now_valid_i;
    end else if (excep_flush_o) begin
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else if (p1) begin
      p1 <= 1'b0;
    end else if (p2) begin
      p2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a queue-based model of pending lines checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         v1, v2;
  logic [153:0] ibus;
  logic         allowin, rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata, dbg_pc;
  logic [3:0]   dbg_we;
  logic         flush;
  logic [31:0]  ex_pc;
  logic [5:0]   ex_ecode;
  logic [75:0]  fwd;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  wb_stage #(.LINE_W(77)) dut (
    .clk(clk), .rst(rst),
    .line1_pre_to_now_valid_i(v1), .line2_pre_to_now_valid_i(v2),
    .now_allowin_o(allowin), .pre_to_ibus(ibus),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .debug_wb_pc_o(dbg_pc), .debug_wb_rf_we_o(dbg_we),
    .excep_flush_o(flush), .excep_pc_o(ex_pc), .excep_ecode_o(ex_ecode),
    .forward_obus(fwd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [76:0] mk(input logic ex, input logic [5:0] ec, input logic [31:0] pc,
                                     input logic we, input logic [4:0] wa, input logic [31:0] wd);
    return {ex, ec, pc, we, wa, wd};
  endfunction

  // model: queue of lines still waiting to commit, oldest first
  typedef struct packed { logic [76:0] rec; logic slot; } ent_t;
  ent_t        pend[$];
  logic [76:0] m_rec1 = '0, m_rec2 = '0;

  function automatic logic writes(input logic [76:0] r);
    return r[37] && !r[76] && (r[36:32] != 5'd0);
  endfunction

  function automatic logic slot_pending(input logic s);
    foreach (pend[i]) if (pend[i].slot == s) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    logic m_flush, m_allow;
    m_flush = (pend.size() > 0) && pend[0].rec[76];
    m_allow = (pend.size() < 2) && !m_flush;
    if (rst) begin
      pend.delete();
      m_rec1 = '0;
      m_rec2 = '0;
    end else if (m_allow) begin
      pend.delete();
      m_rec1 = ibus[76:0];
      m_rec2 = ibus[153:77];
      if (v1) pend.push_back('{rec: ibus[76:0], slot: 1'b0});
      if (v2) pend.push_back('{rec: ibus[153:77], slot: 1'b1});
    end else if (m_flush) begin
      pend.delete();
    end else begin
      void'(pend.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic        has, e_flush, e_we, f1, f2;
      logic [76:0] c;
      has     = pend.size() > 0;
      c       = has ? pend[0].rec : '0;
      e_flush = has && c[76];
      e_we    = has && writes(c);
      f1      = slot_pending(1'b0) && writes(m_rec1);
      f2      = slot_pending(1'b1) && writes(m_rec2);
      chk("allowin", 76'(allowin), 76'((pend.size() < 2) && !e_flush));
      chk("rf_we", 76'(rf_we), 76'(e_we));
      chk("dbg_we", 76'(dbg_we), 76'({4{e_we}}));
      chk("dbg_pc", 76'(dbg_pc), has ? 76'(c[69:38]) : 76'(0));
      if (has) begin
        chk("rf_waddr", 76'(rf_waddr), 76'(c[36:32]));
        chk("rf_wdata", 76'(rf_wdata), 76'(c[31:0]));
      end
      chk("flush", 76'(flush), 76'(e_flush));
      chk("ex_pc", 76'(ex_pc), e_flush ? 76'(c[69:38]) : 76'(0));
      chk("ex_ecode", 76'(ex_ecode), e_flush ? 76'(c[75:70]) : 76'(0));
      chk("forward", fwd, {f2, m_rec2[36:0], f1, m_rec1[36:0]});
    end
  end

  task automatic send(input logic a1, input logic [76:0] l1, input logic a2, input logic [76:0] l2);
    v1 = a1; v2 = a2; ibus = {l2, l1};
    @(negedge clk);
    v1 = 1'b0; v2 = 1'b0;
  endtask

  logic [31:0] got[$];
  logic [31:0] exp_order[4];
  logic [76:0] pa1, pa2, pb1, pb2;

  initial begin
    rst = 1'b1; v1 = 1'b0; v2 = 1'b0; ibus = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset allowin", 76'(allowin), 76'(1));
    chk("reset rf_we", 76'(rf_we), 76'(0));
    chk("reset dbg_pc", 76'(dbg_pc), 76'(0));
    chk("reset forward", fwd, 76'(0));

    // single line
    send(1'b1, mk(0, 0, 32'h1C000000, 1, 5, 32'h12345678), 1'b0, '0);
    chk("single rf_we", 76'(rf_we), 76'(1));
    chk("single waddr", 76'(rf_waddr), 76'(5));
    chk("single wdata", 76'(rf_wdata), 76'(32'h12345678));
    chk("single dbg_we", 76'(dbg_we), 76'(4'hF));
    chk("single allowin", 76'(allowin), 76'(1));
    repeat (2) @(negedge clk);

    // dual line
    send(1'b1, mk(0, 0, 32'h1C000004, 1, 3, 32'hA), 1'b1, mk(0, 0, 32'h1C000008, 1, 4, 32'hB));
    chk("dual c1 waddr", 76'(rf_waddr), 76'(3));
    chk("dual c1 wdata", 76'(rf_wdata), 76'(32'hA));
    chk("dual c1 allowin", 76'(allowin), 76'(0));
    @(negedge clk);
    chk("dual c2 rf_we", 76'(rf_we), 76'(1));
    chk("dual c2 waddr", 76'(rf_waddr), 76'(4));
    chk("dual c2 wdata", 76'(rf_wdata), 76'(32'hB));
    chk("dual c2 allowin", 76'(allowin), 76'(1));
    repeat (2) @(negedge clk);

    // exception in line1 with line2 behind it
    send(1'b1, mk(1, 6'h0B, 32'h1C000010, 1, 6, 32'h66), 1'b1, mk(0, 0, 32'h1C000014, 1, 7, 32'h77));
    chk("exc flush", 76'(flush), 76'(1));
    chk("exc pc", 76'(ex_pc), 76'(32'h1C000010));
    chk("exc ecode", 76'(ex_ecode), 76'(6'h0B));
    chk("exc rf_we", 76'(rf_we), 76'(0));
    chk("exc allowin", 76'(allowin), 76'(0));
    @(negedge clk);
    chk("exc after flush", 76'(flush), 76'(0));
    chk("exc line2 dropped", 76'(rf_we), 76'(0));
    chk("exc after pc", 76'(dbg_pc), 76'(0));
    repeat (2) @(negedge clk);

    // write to r0
    send(1'b1, mk(0, 0, 32'h1C000020, 1, 0, 32'hDEAD), 1'b0, '0);
    chk("r0 rf_we", 76'(rf_we), 76'(0));
    chk("r0 fwd we", 76'(fwd[37]), 76'(0));
    chk("r0 dbg_pc", 76'(dbg_pc), 76'(32'h1C000020));
    repeat (2) @(negedge clk);

    // line2 only
    send(1'b0, '0, 1'b1, mk(0, 0, 32'h1C000030, 1, 9, 32'h99));
    chk("l2only waddr", 76'(rf_waddr), 76'(9));
    chk("l2only rf_we", 76'(rf_we), 76'(1));
    chk("l2only allowin", 76'(allowin), 76'(1));
    @(negedge clk);
    chk("l2only done", 76'(dbg_pc), 76'(0));
    repeat (2) @(negedge clk);

    // reset while line1 of a pair commits
    send(1'b1, mk(0, 0, 32'h1C000040, 1, 1, 32'h1), 1'b1, mk(0, 0, 32'h1C000044, 1, 2, 32'h2));
    chk("rstmid c1 waddr", 76'(rf_waddr), 76'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid rf_we", 76'(rf_we), 76'(0));
    chk("rstmid dbg_pc", 76'(dbg_pc), 76'(0));
    chk("rstmid forward", fwd, 76'(0));
    chk("rstmid allowin", 76'(allowin), 76'(1));
    chk("rstmid waddr", 76'(rf_waddr), 76'(0));
    @(negedge clk);
    chk("rstmid no line2", 76'(rf_we), 76'(0));
    repeat (2) @(negedge clk);

    // back-to-back pairs with valids held high
    pa1 = mk(0, 0, 32'h1C0000A0, 1, 10, 32'hA0);
    pa2 = mk(0, 0, 32'h1C0000A4, 1, 11, 32'hA4);
    pb1 = mk(0, 0, 32'h1C0000B0, 1, 12, 32'hB0);
    pb2 = mk(0, 0, 32'h1C0000B4, 1, 13, 32'hB4);
    exp_order[0] = 32'h1C0000A0; exp_order[1] = 32'h1C0000A4;
    exp_order[2] = 32'h1C0000B0; exp_order[3] = 32'h1C0000B4;
    begin
      int k;
      k = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
        if (rf_we) got.push_back(dbg_pc);
        if (k < 2) begin
          v1 = 1'b1; v2 = 1'b1;
          ibus = (k == 0) ? {pa2, pa1} : {pb2, pb1};
          if (allowin) k++;
        end else begin
          v1 = 1'b0; v2 = 1'b0;
        end
        @(negedge clk);
      end
    end
    chk("b2b count", 76'(got.size()), 76'(4));
    for (int i = 0; i < 4; i++)
      chk("b2b order", (i < got.size()) ? 76'(got[i]) : 76'(0), 76'(exp_order[i]));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter LINE_W, default 77, meaning the width of one line record: {excep(1), ecode(6), pc(32), rf_we(1), rf_waddr(5), rf_wdata(32)}, MSB first.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port line1_pre_to_now_valid_i, input, 1: line1 record from the MEM stage is valid.
REQ-005 SHALL have port line2_pre_to_now_valid_i, input, 1: line2 record from the MEM stage is valid.
REQ-006 SHALL have port now_allowin_o, output, 1: WB accepts a new line pair at this edge.
REQ-007 SHALL have port pre_to_ibus, input, 2*LINE_W: {line2, line1} records.
REQ-008 SHALL have port rf_we_o, input/output direction output, 1: register-file write enable.
REQ-009 SHALL have port rf_waddr_o, output, 5: register-file write address.
REQ-010 SHALL have port rf_wdata_o, output, 32: register-file write data.
REQ-011 SHALL have port debug_wb_pc_o, output, 32: PC of the line committing this cycle.
REQ-012 SHALL have port debug_wb_rf_we_o, output, 4: trace write enable, equal to {4{rf_we_o}}.
REQ-013 SHALL have port excep_flush_o, output, 1: pipeline flush request.
REQ-014 SHALL have port excep_pc_o, output, 32: PC of the excepting line.
REQ-015 SHALL have port excep_ecode_o, output, 6: exception code of the excepting line.
REQ-016 SHALL have port forward_obus, output, 76: {line2 {we, waddr, wdata}, line1 {we, waddr, wdata}}.

Function
REQ-017 SHALL hold two record registers (r1, r2) and two pending flags (p1, p2).
REQ-018 SHALL drive now_allowin_o = !(p1 && p2) && !excep_flush_o.
REQ-019 SHALL, on an edge with now_allowin_o=1, load r1/r2 from pre_to_ibus and set p1 and p2 to the respective valid_i values.
- This load overrides the clears in REQ-021.
REQ-020 SHALL select the commit line each cycle: line1 if p1=1, else line2 if p2=1, else none.
REQ-021 SHALL, at the edge ending a commit cycle, clear the pending flag of the committed line.
- A line pair with both lines pending commits over exactly 2 cycles; line1 always commits before line2.
REQ-022 SHALL assert rf_we_o only when the commit line is selected, its rf_we=1, its excep=0 and rf_waddr!=0; rf_waddr_o and rf_wdata_o SHALL come from the commit line.
REQ-023 SHALL drive debug_wb_pc_o = commit line pc, or 0 when there is no commit line.
REQ-024 SHALL, when the commit line has excep=1:
- assert excep_flush_o for that cycle;
- drive excep_pc_o/excep_ecode_o from that line;
- suppress the write;
- clear both p1 and p2 at the edge, so that a line2 behind an excepting line1 is discarded.
REQ-025 SHALL drive excep_flush_o, excep_pc_o and excep_ecode_o to 0 when there is no excepting commit line.
REQ-026 SHALL ignore the inputs during a flush cycle (now_allowin_o=0), so that no new pair is loaded at that edge.
REQ-027 SHALL set each forward_obus line we = p_n && rf_we && !excep && waddr!=0, with waddr and wdata from the respective record register.
- A committed line's forward entry SHALL drop at the edge that clears its pending flag.
REQ-028 SHALL commit a pair with only line2 valid in 1 cycle, using line2.
REQ-029 SHALL have a latency of one cycle from the accepting edge to rf_we_o for line1.

Reset
REQ-030 SHALL, while rst=1 at an edge, clear p1 and p2 and the record registers.
- After that edge, every output is 0 except now_allowin_o=1.
REQ-031 SHALL make reset dominate a simultaneous load or commit.
- Reset mid-pair discards any uncommitted line2 and produces no write for it.

Verification
REQ-032 SHALL cover a single line:
- stimulus: line1 valid, pc=0x1C000000, rf_we=1, waddr=5, wdata=0x12345678;
- response: next cycle rf_we_o=1, rf_waddr_o=5, debug_wb_rf_we_o=0xF, now_allowin_o=1.
REQ-033 SHALL cover a dual line:
- stimulus: both lines valid, writing r3=0xA and r4=0xB;
- response: cycle 1 writes r3 with now_allowin_o=0; cycle 2 writes r4 with now_allowin_o=1.
REQ-034 SHALL cover an exception in line1:
- stimulus: line1 excep=1, ecode=0x0B, pc=0x1C000010, and line2 valid;
- response: excep_flush_o=1 for 1 cycle with excep_pc_o=0x1C000010, no rf write, line2 never written, now_allowin_o=0 in that cycle.
REQ-035 SHALL cover a write to r0:
- stimulus: line1 rf_we=1, waddr=0;
- response: rf_we_o=0 and forward we=0, while debug_wb_pc_o is still valid.
REQ-036 SHALL cover reset mid-pair:
- stimulus: assert rst in the cycle line1 commits;
- response: the next cycle has no commit, all outputs 0 and now_allowin_o=1.
REQ-037 SHALL cover back-to-back pairs with the MEM valid inputs held high:
- response: no record lost or duplicated; commit order L1a, L2a, L1b, L2b.
